// File: rtl/memory_if.sv
// Signal bundle for the register-file memory/ALU block.
// Clock comes in as an interface port; everything else is a plain interface signal.
interface mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic clk
);
  logic              rst;
  logic              valid;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              carry;
  logic              zero;
  logic              done;

  modport dut (
    input  clk, rst, valid, op, addr_a, addr_b, addr_d, wdata,
    output rdata, carry, zero, done
  );
endinterface

// File: rtl/memory.sv
// Small register-file memory with a built-in ALU: one op per cycle,
// operands read combinationally, result written back and registered on the same edge.
module memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  mem_if.dut bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_WRITE = 3'b001,
    OP_READ  = 3'b010,
    OP_ADD   = 3'b011,
    OP_SUB   = 3'b100,
    OP_AND   = 3'b101,
    OP_OR    = 3'b110,
    OP_XOR   = 3'b111
  } op_t;

  op_t               op_code;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] result;
  logic [DATA_W:0]   wide;
  logic              res_carry;
  logic              store_en;
  logic              accept;

  // Operands come from the pre-edge array, so addr_d aliasing addr_a/addr_b sees old values.
  assign op_code = op_t'(bus.op);
  assign opnd_a  = mem[bus.addr_a];
  assign opnd_b  = mem[bus.addr_b];
  assign accept  = bus.valid && (op_code != OP_NOP);

  always_comb begin
    result    = '0;
    res_carry = 1'b0;
    store_en  = 1'b0;
    wide      = '0;
    case (op_code)
      OP_WRITE: begin
        result   = bus.wdata;
        store_en = 1'b1;
      end
      OP_READ: result = opnd_a;
      OP_ADD: begin
        wide      = {1'b0, opnd_a} + {1'b0, opnd_b};
        result    = wide[DATA_W-1:0];
        res_carry = wide[DATA_W];
        store_en  = 1'b1;
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is exactly the borrow (a < b).
        wide      = {1'b0, opnd_a} - {1'b0, opnd_b};
        result    = wide[DATA_W-1:0];
        res_carry = wide[DATA_W];
        store_en  = 1'b1;
      end
      OP_AND: begin
        result   = opnd_a & opnd_b;
        store_en = 1'b1;
      end
      OP_OR: begin
        result   = opnd_a | opnd_b;
        store_en = 1'b1;
      end
      OP_XOR: begin
        result   = opnd_a ^ opnd_b;
        store_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge bus.clk or negedge bus.rst) begin
    if (!bus.rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.rdata <= '0;
      bus.carry <= 1'b0;
      bus.zero  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= accept;
      if (accept) begin
        bus.rdata <= result;
        bus.carry <= res_carry;
        bus.zero  <= (result == '0);
        if (store_en) mem[bus.addr_d] <= result;
      end
    end
  end
endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: each op is driven at a falling edge and its
// registered results are checked at the next falling edge.
module tb_memory;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  localparam logic [2:0] NOP = 3'b000, WR = 3'b001, RD = 3'b010, ADD = 3'b011,
                         SUB = 3'b100, AND_OP = 3'b101, OR_OP = 3'b110, XOR_OP = 3'b111;

  logic clk = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus (.clk(clk));

  memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.bus(bus));

  // Presents one request for exactly one rising edge and returns at the following falling edge.
  task automatic apply_stimulus(input logic v, input logic [2:0] op,
                                input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                                input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] wd);
    bus.valid  = v;
    bus.op     = op;
    bus.addr_a = a;
    bus.addr_b = b;
    bus.addr_d = d;
    bus.wdata  = wd;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.op    = NOP;
  endtask

  task automatic check_output(input string tag, input logic [DATA_W-1:0] exp_rdata,
                              input logic exp_carry, input logic exp_zero, input logic exp_done);
    vectors++;
    assert (bus.rdata === exp_rdata) else begin
      miscompares++;
      $error("[TB] FAIL %s rdata observed=%h expected=%h", tag, bus.rdata, exp_rdata);
    end
    vectors++;
    assert (bus.carry === exp_carry) else begin
      miscompares++;
      $error("[TB] FAIL %s carry observed=%b expected=%b", tag, bus.carry, exp_carry);
    end
    vectors++;
    assert (bus.zero === exp_zero) else begin
      miscompares++;
      $error("[TB] FAIL %s zero observed=%b expected=%b", tag, bus.zero, exp_zero);
    end
    vectors++;
    assert (bus.done === exp_done) else begin
      miscompares++;
      $error("[TB] FAIL %s done observed=%b expected=%b", tag, bus.done, exp_done);
    end
  endtask

  initial begin
    bus.rst    = 1'b0;
    bus.valid  = 1'b0;
    bus.op     = NOP;
    bus.addr_a = '0;
    bus.addr_b = '0;
    bus.addr_d = '0;
    bus.wdata  = '0;
    $display("[TB] starting directed sequence");

    @(negedge clk);
    @(negedge clk);
    check_output("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.rst = 1'b1;

    apply_stimulus(1'b1, RD, 4'd5, 4'd0, 4'd0, 8'h00);
    check_output("read_after_reset", 8'h00, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_output("done_one_cycle", 8'h00, 1'b0, 1'b1, 1'b0);

    apply_stimulus(1'b1, WR, 4'd0, 4'd0, 4'd1, 8'hF0);
    check_output("write_1_f0", 8'hF0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, WR, 4'd0, 4'd0, 4'd2, 8'h20);
    check_output("write_2_20", 8'h20, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, ADD, 4'd1, 4'd2, 4'd3, 8'h00);
    check_output("add_carry", 8'h10, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, RD, 4'd3, 4'd0, 4'd0, 8'h00);
    check_output("read_3", 8'h10, 1'b0, 1'b0, 1'b1);

    apply_stimulus(1'b1, SUB, 4'd2, 4'd1, 4'd4, 8'h00);
    check_output("sub_borrow", 8'h30, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, SUB, 4'd1, 4'd2, 4'd5, 8'h00);
    check_output("sub_no_borrow", 8'hD0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, RD, 4'd4, 4'd0, 4'd0, 8'h00);
    check_output("read_4", 8'h30, 1'b0, 1'b0, 1'b1);

    apply_stimulus(1'b1, WR, 4'd0, 4'd0, 4'd1, 8'hAA);
    check_output("write_1_aa", 8'hAA, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, WR, 4'd0, 4'd0, 4'd2, 8'h55);
    check_output("write_2_55", 8'h55, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, SUB, 4'd2, 4'd1, 4'd10, 8'h00);
    check_output("sub_55_aa", 8'hAB, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, AND_OP, 4'd1, 4'd2, 4'd7, 8'h00);
    check_output("and", 8'h00, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b1, OR_OP, 4'd1, 4'd2, 4'd8, 8'h00);
    check_output("or", 8'hFF, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, XOR_OP, 4'd1, 4'd2, 4'd9, 8'h00);
    check_output("xor", 8'hFF, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, RD, 4'd7, 4'd0, 4'd0, 8'h00);
    check_output("read_7", 8'h00, 1'b0, 1'b1, 1'b1);

    apply_stimulus(1'b1, NOP, 4'd0, 4'd0, 4'd0, 8'h5A);
    check_output("nop_holds", 8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, WR, 4'd0, 4'd0, 4'd0, 8'h5A);
    check_output("invalid_holds", 8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, RD, 4'd0, 4'd0, 4'd0, 8'h00);
    check_output("read_0_unwritten", 8'h00, 1'b0, 1'b1, 1'b1);

    apply_stimulus(1'b1, WR, 4'd0, 4'd0, 4'd11, 8'h03);
    check_output("write_11", 8'h03, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, ADD, 4'd11, 4'd11, 4'd11, 8'h00);
    check_output("add_alias_1", 8'h06, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, ADD, 4'd11, 4'd11, 4'd11, 8'h00);
    check_output("add_alias_2", 8'h0C, 1'b0, 1'b0, 1'b1);

    apply_stimulus(1'b1, WR, 4'd0, 4'd0, 4'd12, 8'hFF);
    check_output("write_12", 8'hFF, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, WR, 4'd0, 4'd0, 4'd13, 8'h01);
    check_output("write_13", 8'h01, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, ADD, 4'd12, 4'd13, 4'd14, 8'h00);
    check_output("add_wrap", 8'h00, 1'b1, 1'b1, 1'b1);

    apply_stimulus(1'b1, WR, 4'd0, 4'd0, 4'd6, 8'h07);
    check_output("write_6", 8'h07, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, ADD, 4'd6, 4'd6, 4'd6, 8'h00);
    check_output("b2b_add_6", 8'h0E, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, RD, 4'd6, 4'd0, 4'd0, 8'h00);
    check_output("read_6", 8'h0E, 1'b0, 1'b0, 1'b1);

    // Reset dropped between edges must clear outputs without waiting for a clock.
    #2;
    bus.rst = 1'b0;
    #1;
    check_output("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.valid  = 1'b1;
    bus.op     = WR;
    bus.addr_d = 4'd15;
    bus.wdata  = 8'h77;
    @(negedge clk);
    check_output("held_in_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.valid = 1'b0;
    bus.op    = NOP;
    bus.rst   = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, RD, i[ADDR_W-1:0], 4'd0, 4'd0, 8'h00);
      check_output($sformatf("read_cleared_%0d", i), 8'h00, 1'b0, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth 2**ADDR_W words (16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 valid  input  1  operation request, sampled on rising clk.
REQ-006 op  input  3  opcode: 000 NOP, 001 WRITE, 010 READ, 011 ADD, 100 SUB, 101 AND, 110 OR, 111 XOR.
REQ-007 addr_a  input  ADDR_W  first operand / read address.
REQ-008 addr_b  input  ADDR_W  second operand address.
REQ-009 addr_d  input  ADDR_W  destination address (WRITE and ALU ops).
REQ-010 wdata  input  DATA_W  write data for WRITE.
REQ-011 rdata  output  DATA_W  registered read / ALU result data.
REQ-012 carry  output  1  registered carry (ADD) or borrow (SUB) flag.
REQ-013 zero  output  1  registered flag, 1 when rdata result equals 0.
REQ-014 done  output  1  one-cycle pulse marking a completed operation.
REQ-015 Ports SHALL be bundled in interface mem_if (clk passed as interface port); memory SHALL take the mem_if instance as its only port.

Function
REQ-016 Storage SHALL be a 2**ADDR_W x DATA_W register array, read combinationally, written on rising clk.
REQ-017 Operation accepted on a rising edge where valid=1; valid=0 or op=NOP SHALL leave array, rdata, carry, zero unchanged and done=0 next cycle.
REQ-018 WRITE: mem[addr_d] <= wdata; rdata <= wdata; carry <= 0; zero <= (wdata==0).
REQ-019 READ: rdata <= mem[addr_a]; carry <= 0; zero updated; array unchanged.
REQ-020 ADD: {carry, r} = mem[addr_a] + mem[addr_b] computed DATA_W+1 bits wide; mem[addr_d] <= r; rdata <= r.
REQ-021 SUB: r = mem[addr_a] - mem[addr_b] modulo 2**DATA_W; carry <= 1 when mem[addr_a] < mem[addr_b] (borrow); result stored to mem[addr_d] and rdata.
REQ-022 AND/OR/XOR: bitwise on mem[addr_a], mem[addr_b]; stored to mem[addr_d] and rdata; carry <= 0.
REQ-023 zero SHALL equal (new rdata == 0) for every accepted non-NOP op.
REQ-024 Latency: outputs and array update on the same edge that accepts the op; done=1 for exactly the following cycle; throughput one op per cycle, no backpressure.
REQ-025 Back-to-back ops: an op SHALL read array contents including the write of the immediately preceding op (no hazard stall).
REQ-026 Operands read before write on the same edge: addr_d equal to addr_a or addr_b uses old operand values.
REQ-027 Arithmetic SHALL wrap silently modulo 2**DATA_W; addresses have no out-of-range case.

Reset
REQ-028 rst=0 SHALL immediately, independent of clk, clear all array words, rdata, carry, zero, done to 0.
REQ-029 Reset asserted mid-operation SHALL discard that operation; first op accepted on first rising edge with rst=1 and valid=1.

Verification
REQ-030 Reset then READ addr_a=5 -> rdata=0x00, zero=1, carry=0, done pulses one cycle.
REQ-031 WRITE addr_d=1 wdata=0xF0, WRITE addr_d=2 wdata=0x20, ADD a=1 b=2 d=3 -> rdata=0x10, carry=1; READ a=3 -> 0x10.
REQ-032 SUB a=2 b=1 d=4 with mem[2]=0x20, mem[1]=0xF0 -> rdata=0x30, carry=1; SUB a=1 b=2 -> 0xD0, carry=0.
REQ-033 mem[1]=0xAA, mem[2]=0x55: AND -> 0x00 zero=1; OR -> 0xFF; XOR -> 0xFF; carry=0 each.
REQ-034 Back-to-back WRITE d=6 0x07 then ADD a=6 b=6 d=6 -> 0x0E; next READ a=6 -> 0x0E.
REQ-035 Assert rst low between edges after writes -> all outputs 0 immediately; READ of every address returns 0.
